// File: rtl/packet_dst_latch_if.sv
// AXI4-Stream bundle between the port lookup, packet_dst_latch and the output queues.
interface packet_dst_latch_if #(
  parameter int unsigned DataWidth  = 256,
  parameter int unsigned TuserWidth = 128
);
  logic [DataWidth-1:0]   tdata;
  logic [DataWidth/8-1:0] tkeep;
  logic [TuserWidth-1:0]  tuser;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (
    output tdata,
    output tkeep,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/packet_dst_latch.sv
// Latches the pruned destination bitmap from beat 0 and stamps it on every beat of the packet.
// Define DROP_COUNTER_EN to add the saturating drop_count output.
module packet_dst_latch #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned SRC_PORT_POS         = 16,
  parameter int unsigned DST_PORT_POS         = 24,
  parameter logic [7:0]  PORT_MASK            = 8'hFF
) (
  input  logic                 axis_aclk,
  input  logic                 axis_reset,
  packet_dst_latch_if.slave    s_axis,
  packet_dst_latch_if.master   m_axis
`ifdef DROP_COUNTER_EN
  ,
  output logic [31:0]          drop_count
`endif
);

  localparam int unsigned DW = C_M_AXIS_DATA_WIDTH;
  localparam int unsigned KW = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW = C_M_AXIS_TUSER_WIDTH;

  if ((C_S_AXIS_DATA_WIDTH != C_M_AXIS_DATA_WIDTH) ||
      (C_S_AXIS_TUSER_WIDTH != C_M_AXIS_TUSER_WIDTH)) begin : g_width_check
    $error("packet_dst_latch: slave and master widths must match");
  end

  typedef enum logic [1:0] {StHdr, StFwd, StDrop} state_e;

  state_e          state_q, state_d;
  logic [UW-1:0]   tuser_q, tuser_d;
  logic [UW-1:0]   hdr_tuser, push_tuser;
  logic [7:0]      dst;
  logic            accept, push, pop;
  logic            ready_q;
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, rd_ptr_q;

  logic [DW-1:0]   data_q  [2];
  logic [KW-1:0]   keep_q  [2];
  logic [UW-1:0]   user_q  [2];
  logic            last_q  [2];

  // DROP never pushes, so it may swallow beats even with a full buffer.
  assign s_axis.tready = (state_q == StDrop) | ready_q;
  assign accept        = s_axis.tvalid & s_axis.tready;

  assign m_axis.tvalid = (count_q != 2'd0);
  assign m_axis.tdata  = data_q[rd_ptr_q];
  assign m_axis.tkeep  = keep_q[rd_ptr_q];
  assign m_axis.tuser  = user_q[rd_ptr_q];
  assign m_axis.tlast  = last_q[rd_ptr_q];
  assign pop           = m_axis.tvalid & m_axis.tready;

  always_comb begin
    dst       = s_axis.tuser[DST_PORT_POS +: 8] & PORT_MASK & ~s_axis.tuser[SRC_PORT_POS +: 8];
    hdr_tuser = s_axis.tuser;
    hdr_tuser[DST_PORT_POS +: 8] = dst;
  end

  always_comb begin
    state_d    = state_q;
    tuser_d    = tuser_q;
    push       = 1'b0;
    push_tuser = tuser_q;
    unique case (state_q)
      StHdr: begin
        if (accept) begin
          tuser_d    = hdr_tuser;
          push_tuser = hdr_tuser;
          if (dst != 8'h00) begin
            push    = 1'b1;
            state_d = s_axis.tlast ? StHdr : StFwd;
          end else begin
            state_d = s_axis.tlast ? StHdr : StDrop;
          end
        end
      end
      StFwd: begin
        if (accept) begin
          push = 1'b1;
          if (s_axis.tlast) state_d = StHdr;
        end
      end
      StDrop: begin
        if (accept && s_axis.tlast) state_d = StHdr;
      end
      default: state_d = StHdr;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q  <= StHdr;
      tuser_q  <= '0;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        keep_q[i] <= '0;
        user_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      tuser_q <= tuser_d;
      count_q <= count_d;
      // Registered ready equals "next occupancy below 2", so a push can never overflow.
      ready_q <= (count_d != 2'd2);
      if (push) begin
        data_q[wr_ptr_q] <= s_axis.tdata;
        keep_q[wr_ptr_q] <= s_axis.tkeep;
        user_q[wr_ptr_q] <= push_tuser;
        last_q[wr_ptr_q] <= s_axis.tlast;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

`ifdef DROP_COUNTER_EN
  logic        drop_hdr;
  logic [31:0] drop_count_q;

  assign drop_hdr   = accept && (state_q == StHdr) && (dst == 8'h00);
  assign drop_count = drop_count_q;

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      drop_count_q <= 32'd0;
    end else if (drop_hdr && (drop_count_q != 32'hFFFF_FFFF)) begin
      drop_count_q <= drop_count_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_packet_dst_latch.sv
// Directed bench for packet_dst_latch with a queue scoreboard of expected master-side beats.
module tb_packet_dst_latch;
  localparam int unsigned DW = 256;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned UW = 128;

  logic clk = 1'b0;
  logic axis_reset = 1'b1;
  always #5 clk = ~clk;

  packet_dst_latch_if #(.DataWidth(DW), .TuserWidth(UW)) s_if ();
  packet_dst_latch_if #(.DataWidth(DW), .TuserWidth(UW)) m_if ();
  packet_dst_latch_if #(.DataWidth(DW), .TuserWidth(UW)) s2_if ();
  packet_dst_latch_if #(.DataWidth(DW), .TuserWidth(UW)) m2_if ();

`ifdef DROP_COUNTER_EN
  logic [31:0] dc, dc2;
`endif

  packet_dst_latch dut (
    .axis_aclk  (clk),
    .axis_reset (axis_reset),
    .s_axis     (s_if),
    .m_axis     (m_if)
`ifdef DROP_COUNTER_EN
    ,
    .drop_count (dc)
`endif
  );

  // Second instance with a narrowed port mask, fed the same stream, never backpressured.
  packet_dst_latch #(.PORT_MASK(8'h0F)) dut_mask (
    .axis_aclk  (clk),
    .axis_reset (axis_reset),
    .s_axis     (s2_if),
    .m_axis     (m2_if)
`ifdef DROP_COUNTER_EN
    ,
    .drop_count (dc2)
`endif
  );

  assign s2_if.tdata  = s_if.tdata;
  assign s2_if.tkeep  = s_if.tkeep;
  assign s2_if.tuser  = s_if.tuser;
  assign s2_if.tvalid = s_if.tvalid;
  assign s2_if.tlast  = s_if.tlast;
  assign m2_if.tready = 1'b1;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  beat_t         expq[$];
  beat_t         mb;
  int            n_vec = 0;
  int            n_err = 0;
  int            exp_drops = 0;
  bit            in_pkt = 1'b0;
  bit            fwd = 1'b0;
  logic [UW-1:0] lat_u;
  int            mode = 0;  // 0: ready, 1: 1,0,0,1 pattern, 2: stalled
  int            cyc = 0;
  logic [3:0]    tog_pat = 4'b1001;

  assign m_if.tready = (mode == 0) || ((mode == 1) && tog_pat[cyc[1:0]]);

  initial forever begin
    @(posedge clk);
    #1 cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [UW-1:0] mk_u(input logic [7:0] dst, input logic [7:0] src,
                                          input logic [15:0] lo);
    return {96'hA5A5_0001_1234_5678_9ABC_DEF0, dst, src, lo};
  endfunction

  function automatic logic [DW-1:0] rnd_d();
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d, input logic [KW-1:0] k,
                              input logic [UW-1:0] u, input logic l);
    beat_t      b;
    logic [7:0] dst;
    if (!in_pkt) begin
      dst   = u[31:24] & ~u[23:16];
      lat_u = u;
      lat_u[31:24] = dst;
      fwd   = (dst != 8'h00);
      if (!fwd) exp_drops++;
    end
    in_pkt = !l;
    if (fwd) begin
      b.d = d; b.k = k; b.u = lat_u; b.l = l;
      expq.push_back(b);
    end
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic [UW-1:0] u,
                      input logic l, input bit chk_rdy);
    bit done;
    done = 1'b0;
    s_if.tdata = d; s_if.tkeep = k; s_if.tuser = u; s_if.tlast = l; s_if.tvalid = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (chk_rdy && n == 0) check("drop_ready", s_if.tready, 1'b1);
      if (s_if.tready) begin
        model_accept(d, k, u, l);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("send_done", done, 1'b1);
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", expq.size(), 0);
  endtask

  task automatic check_drops();
`ifdef DROP_COUNTER_EN
    check("drop_count", dc, exp_drops);
`endif
  endtask

  always @(negedge clk) begin
    if (!axis_reset && m_if.tvalid && m_if.tready) begin
      if (expq.size() == 0) begin
        check("extra_beat", m_if.tvalid, 1'b0);
      end else begin
        mb = expq.pop_front();
        check("tdata", m_if.tdata, mb.d);
        check("tkeep", m_if.tkeep, mb.k);
        check("tuser", m_if.tuser, mb.u);
        check("tlast", m_if.tlast, mb.l);
      end
    end
  end

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    axis_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_if.tvalid, 1'b0);
    check("rst_tdata", m_if.tdata, '0);
    check("rst_tkeep", m_if.tkeep, '0);
    check("rst_tuser", m_if.tuser, '0);
    check("rst_tlast", m_if.tlast, 1'b0);
    check("rst_tready", s_if.tready, 1'b0);
    check_drops();
    @(posedge clk); #1 axis_reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_rst", s_if.tready, 1'b1);
    @(posedge clk); #1;

    // Narrow mask: F1 with no source bit reduces to 01.
    send(rnd_d(), '1, mk_u(8'hF1, 8'h00, 16'h0001), 1'b1, 1'b0);
    @(negedge clk);
    check("mask_valid", m2_if.tvalid, 1'b1);
    check("mask_dst", m2_if.tuser[31:24], 8'h01);
    @(posedge clk); #1;

    // 4-beat packet; body beats carry DST 00 but must emit the latched 10.
    send(rnd_d(), '1, mk_u(8'h10, 8'h01, 16'h0002), 1'b0, 1'b0);
    @(negedge clk);
    check("latency_valid", m_if.tvalid, 1'b1);
    check("latency_dst", m_if.tuser[31:24], 8'h10);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      send(rnd_d(), KW'($urandom), {$urandom, $urandom, $urandom, 16'h0000, 16'h1111},
           (i == 2), 1'b0);

    // Source pruning empties the set: the packet is silently dropped.
    send(rnd_d(), '1, mk_u(8'h04, 8'h04, 16'h0003), 1'b0, 1'b0);
    send(rnd_d(), '1, mk_u(8'h00, 8'h00, 16'h0004), 1'b0, 1'b1);
    send(rnd_d(), '1, mk_u(8'h00, 8'h00, 16'h0005), 1'b1, 1'b1);
    check_drops();
    send(rnd_d(), '1, mk_u(8'h01, 8'h00, 16'h0006), 1'b0, 1'b0);
    send(rnd_d(), '1, mk_u(8'h00, 8'h00, 16'h0007), 1'b1, 1'b0);

    // PTP-style header: AA with source 02 -> A8.
    send(rnd_d(), '1, mk_u(8'hAA, 8'h02, 16'h0008), 1'b0, 1'b0);
    send(rnd_d(), KW'($urandom), mk_u(8'h55, 8'h00, 16'h0009), 1'b1, 1'b0);
    wait_drain();

    // Stalled master: two beats fill the buffer, then ready falls and the head is held.
    mode = 2;
    send(rnd_d(), '1, mk_u(8'h01, 8'h80, 16'h000A), 1'b0, 1'b0);
    send(rnd_d(), '1, mk_u(8'h00, 8'h00, 16'h000B), 1'b1, 1'b0);
    @(negedge clk);
    check("bp_ready_low", s_if.tready, 1'b0);
    check("bp_hold_valid", m_if.tvalid, 1'b1);
    @(posedge clk); #1;
    mode = 1;
    for (int p = 0; p < 4; p++) begin
      send(rnd_d(), KW'($urandom), mk_u(8'(1 << p), 8'h80, 16'(p)), 1'b0, 1'b0);
      send(rnd_d(), KW'($urandom), mk_u(8'hFF, 8'h00, 16'(p + 100)), 1'b1, 1'b0);
    end
    mode = 0;
    wait_drain();

    // Single-beat packets alternating forward/drop at full rate.
    for (int i = 0; i < 6; i++)
      send(rnd_d(), '1, mk_u((i % 2 == 0) ? 8'h01 : 8'h00, 8'h80, 16'(i + 200)), 1'b1, 1'b0);
    wait_drain();
    check_drops();

    // Reset pulse during beat 2 of a 5-beat packet.
    send(rnd_d(), '1, mk_u(8'h02, 8'h01, 16'h0300), 1'b0, 1'b0);
    send(rnd_d(), '1, mk_u(8'h00, 8'h00, 16'h0301), 1'b0, 1'b0);
    s_if.tdata = rnd_d(); s_if.tuser = mk_u(8'h00, 8'h00, 16'h0302); s_if.tlast = 1'b0;
    s_if.tvalid = 1'b1;
    axis_reset = 1'b1;
    @(posedge clk); #1;
    axis_reset = 1'b0;
    s_if.tvalid = 1'b0;
    expq.delete();
    in_pkt = 1'b0;
    exp_drops = 0;
    @(negedge clk);
    check("rst_mid_valid", m_if.tvalid, 1'b0);
    check("rst_mid_ready", s_if.tready, 1'b0);
    check_drops();
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_ready2", s_if.tready, 1'b1);
    @(posedge clk); #1;
    // Beat 3 now counts as a header with an empty set, so the rest is dropped.
    send(rnd_d(), '1, mk_u(8'h00, 8'h00, 16'h0303), 1'b0, 1'b0);
    send(rnd_d(), '1, mk_u(8'h00, 8'h00, 16'h0304), 1'b1, 1'b1);
    check_drops();
    send(rnd_d(), '1, mk_u(8'h40, 8'h01, 16'h0305), 1'b1, 1'b0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
